// File: rtl/riscv_v_rf_scoreboard.sv
// Vector register-file hazard scoreboard: per-register in-flight write counters
// gating issue on RAW hazards and counter saturation, released by writeback/kill.
module riscv_v_rf_scoreboard #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int NUM_REGS      = 2**RF_ADDR_WIDTH,
  parameter int CNT_WIDTH     = 2,
  parameter int BYPASS        = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [RF_ADDR_WIDTH-1:0] issue_rd,
  input  logic                     issue_rd_we,
  input  logic [RF_ADDR_WIDTH-1:0] issue_rs1,
  input  logic [RF_ADDR_WIDTH-1:0] issue_rs2,
  input  logic [RF_ADDR_WIDTH-1:0] issue_rs3,
  input  logic [2:0]               issue_rs_re,
  output logic                     issue_ready,
  input  logic                     wb_valid,
  input  logic [RF_ADDR_WIDTH-1:0] wb_rd,
  input  logic                     kill_valid,
  input  logic [RF_ADDR_WIDTH-1:0] kill_rd,
  output logic [NUM_REGS-1:0]      busy,
  output logic                     idle,
  output logic                     err
);

  localparam int SW = CNT_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0]     cnt      [NUM_REGS];
  logic [CNT_WIDTH-1:0]     cnt_next [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_next;
  logic                     under;
  logic                     raw;
  logic                     sat;
  logic                     accept;
  logic [RF_ADDR_WIDTH-1:0] src [3];
  logic [SW-1:0]            sum;
  logic [SW-1:0]            dec;

  assign src[0] = issue_rs1;
  assign src[1] = issue_rs2;
  assign src[2] = issue_rs3;

  // Bypass only on a writeback that retires the last outstanding write; kills never bypass.
  always_comb begin
    raw = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (issue_rs_re[k] && cnt[src[k]] != '0 &&
          !(BYPASS != 0 && cnt[src[k]] == CNT_WIDTH'(1) && wb_valid && wb_rd == src[k]))
        raw = 1'b1;
    end
    sat         = issue_rd_we && cnt[issue_rd] == CNT_MAX;
    issue_ready = !(raw || sat);
  end

  assign accept = issue_valid && issue_ready;

  always_comb begin
    under     = 1'b0;
    busy_next = '0;
    sum       = '0;
    dec       = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      sum = {{(SW-CNT_WIDTH){1'b0}}, cnt[i]}
          + SW'(accept && issue_rd_we && issue_rd == RF_ADDR_WIDTH'(i));
      dec = SW'(wb_valid && wb_rd == RF_ADDR_WIDTH'(i))
          + SW'(kill_valid && kill_rd == RF_ADDR_WIDTH'(i));
      if (dec > sum) begin
        cnt_next[i] = '0;
        under       = 1'b1;
      end else begin
        cnt_next[i] = CNT_WIDTH'(sum - dec);
      end
      busy_next[i] = cnt_next[i] != '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      busy <= '0;
      idle <= 1'b1;
      err  <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      busy <= busy_next;
      idle <= ~|busy_next;
      err  <= err | under;
    end
  end

endmodule

// File: tb/tb_riscv_v_rf_scoreboard.sv
// Self-checking bench: a counter model pushes expected {busy,idle,err} per cycle,
// popped and compared after each clock edge; issue_ready checked against scenario constants.
module tb_riscv_v_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst, issue_valid, issue_rd_we, wb_valid, kill_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2, issue_rs3, wb_rd, kill_rd;
  logic [2:0]  issue_rs_re;
  logic        issue_ready, idle, err;
  logic [31:0] busy;

  int          passed = 0;
  int          total  = 0;
  int          mcnt [32];
  logic        merr = 1'b0;
  logic [33:0] sb [$];
  logic [33:0] exp_v, obs_v;
  logic        rdy;

  riscv_v_rf_scoreboard #(.RF_ADDR_WIDTH(5), .CNT_WIDTH(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rd_we(issue_rd_we), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs3(issue_rs3), .issue_rs_re(issue_rs_re), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .kill_valid(kill_valid), .kill_rd(kill_rd),
    .busy(busy), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  // Drive one cycle, sample issue_ready, advance the model and push its expectation.
  task automatic step(input logic r, input logic iv, input logic [4:0] rd, input logic we,
                      input logic [4:0] s, input logic [2:0] re,
                      input logic wv, input logic [4:0] wrd,
                      input logic kv, input logic [4:0] krd,
                      input logic er, output logic ob);
    logic [31:0] eb;
    int inc, dec;
    @(negedge clk);
    rst = r; issue_valid = iv; issue_rd = rd; issue_rd_we = we;
    issue_rs1 = s; issue_rs2 = s; issue_rs3 = s; issue_rs_re = re;
    wb_valid = wv; wb_rd = wrd; kill_valid = kv; kill_rd = krd;
    #1 ob = issue_ready;
    for (int i = 0; i < 32; i++) begin
      if (r) mcnt[i] = 0;
      else begin
        inc = (iv && er && we && rd == 5'(i)) ? 1 : 0;
        dec = ((wv && wrd == 5'(i)) ? 1 : 0) + ((kv && krd == 5'(i)) ? 1 : 0);
        if (dec > mcnt[i] + inc) begin mcnt[i] = 0; merr = 1'b1; end
        else mcnt[i] = mcnt[i] + inc - dec;
      end
      eb[i] = mcnt[i] != 0;
    end
    if (r) merr = 1'b0;
    sb.push_back({eb, eb == 32'd0, merr});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 5'd1, 1, 5'd0, 3'b000, 1, 5'd1, 1, 5'd2, 1, rdy);
    obs_v = {busy, idle, err}; exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v) $display("FAIL reset_state: busy/idle/err=%h required %h", obs_v, exp_v);
    else passed++;
    step(0, 0, 5'd0, 0, 5'd17, 3'b111, 0, 5'd0, 0, 5'd0, 1, rdy);
    total++;
    if (rdy !== 1'b1) $display("FAIL reset_ready: issue_ready=%b required 1", rdy); else passed++;
    obs_v = {busy, idle, err}; exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v) $display("FAIL reset_idle: busy/idle/err=%h required %h", obs_v, exp_v);
    else passed++;
  endtask

  task automatic test_raw();
    step(0, 1, 5'd3, 1, 5'd0, 3'b000, 0, 5'd0, 0, 5'd0, 1, rdy);
    obs_v = {busy, idle, err}; exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v || busy[3] !== 1'b1)
      $display("FAIL raw_busy3: busy/idle/err=%h required %h", obs_v, exp_v);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      step(0, k[0], 5'd0, 0, 5'd3, 3'(1 << k), 0, 5'd0, 0, 5'd0, 0, rdy);
      total++;
      if (rdy !== 1'b0) $display("FAIL raw_stall_rs%0d: issue_ready=%b required 0", k + 1, rdy);
      else passed++;
      void'(sb.pop_front());
    end
    step(0, 1, 5'd0, 0, 5'd3, 3'b000, 0, 5'd0, 0, 5'd0, 1, rdy);
    total++;
    if (rdy !== 1'b1) $display("FAIL raw_re_gated: issue_ready=%b required 1", rdy); else passed++;
    void'(sb.pop_front());
    step(0, 1, 5'd0, 0, 5'd3, 3'b001, 1, 5'd3, 0, 5'd0, 1, rdy);
    total++;
    if (rdy !== 1'b1) $display("FAIL raw_bypass: issue_ready=%b required 1", rdy); else passed++;
    obs_v = {busy, idle, err}; exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v || busy[3] !== 1'b0)
      $display("FAIL raw_release: busy/idle/err=%h required %h", obs_v, exp_v);
    else passed++;
    step(0, 1, 5'd3, 1, 5'd0, 3'b000, 0, 5'd0, 0, 5'd0, 1, rdy);
    void'(sb.pop_front());
    step(0, 1, 5'd0, 0, 5'd3, 3'b001, 0, 5'd0, 1, 5'd3, 0, rdy);
    total++;
    if (rdy !== 1'b0) $display("FAIL raw_kill_no_bypass: issue_ready=%b required 0", rdy); else passed++;
    obs_v = {busy, idle, err}; exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v) $display("FAIL raw_kill_release: busy/idle/err=%h required %h", obs_v, exp_v);
    else passed++;
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 5'd7, 1, 5'd0, 3'b000, 0, 5'd0, 0, 5'd0, 1, rdy);
      total++;
      if (rdy !== 1'b1) $display("FAIL sat_fill%0d: issue_ready=%b required 1", k, rdy); else passed++;
      void'(sb.pop_front());
    end
    step(0, 1, 5'd7, 1, 5'd0, 3'b000, 1, 5'd7, 0, 5'd0, 0, rdy);
    total++;
    if (rdy !== 1'b0) $display("FAIL sat_block: issue_ready=%b required 0", rdy); else passed++;
    void'(sb.pop_front());
    step(0, 1, 5'd7, 1, 5'd0, 3'b000, 0, 5'd0, 0, 5'd0, 1, rdy);
    total++;
    if (rdy !== 1'b1) $display("FAIL sat_after_wb: issue_ready=%b required 1", rdy); else passed++;
    void'(sb.pop_front());
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 5'd0, 0, 5'd0, 3'b000, 1, 5'd7, 0, 5'd0, 1, rdy);
      obs_v = {busy, idle, err}; exp_v = sb.pop_front(); total++;
      if (obs_v !== exp_v) $display("FAIL sat_drain%0d: busy/idle/err=%h required %h", k, obs_v, exp_v);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    step(0, 1, 5'd5, 1, 5'd0, 3'b000, 0, 5'd0, 0, 5'd0, 1, rdy);
    void'(sb.pop_front());
    step(0, 1, 5'd5, 1, 5'd0, 3'b000, 1, 5'd5, 0, 5'd0, 1, rdy);
    obs_v = {busy, idle, err}; exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v || busy[5] !== 1'b1)
      $display("FAIL simul_hold: busy/idle/err=%h required %h", obs_v, exp_v);
    else passed++;
    step(0, 0, 5'd0, 0, 5'd0, 3'b000, 1, 5'd5, 0, 5'd0, 1, rdy);
    obs_v = {busy, idle, err}; exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v || idle !== 1'b1)
      $display("FAIL simul_cnt1: busy/idle/err=%h required %h", obs_v, exp_v);
    else passed++;
  endtask

  task automatic test_kill_wb();
    step(0, 1, 5'd9, 1, 5'd0, 3'b000, 0, 5'd0, 0, 5'd0, 1, rdy);
    void'(sb.pop_front());
    step(0, 1, 5'd9, 1, 5'd0, 3'b000, 0, 5'd0, 0, 5'd0, 1, rdy);
    void'(sb.pop_front());
    step(0, 0, 5'd0, 0, 5'd0, 3'b000, 1, 5'd9, 1, 5'd9, 1, rdy);
    obs_v = {busy, idle, err}; exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v || busy[9] !== 1'b0 || idle !== 1'b1 || err !== 1'b0)
      $display("FAIL kill_wb: busy/idle/err=%h required %h", obs_v, exp_v);
    else passed++;
  endtask

  task automatic test_underflow_reset();
    step(0, 0, 5'd0, 0, 5'd0, 3'b000, 1, 5'd4, 0, 5'd0, 1, rdy);
    obs_v = {busy, idle, err}; exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v || err !== 1'b1)
      $display("FAIL underflow_err: busy/idle/err=%h required %h", obs_v, exp_v);
    else passed++;
    step(0, 1, 5'd2, 1, 5'd0, 3'b000, 0, 5'd0, 0, 5'd0, 1, rdy);
    void'(sb.pop_front());
    step(0, 1, 5'd6, 1, 5'd0, 3'b000, 0, 5'd0, 0, 5'd0, 1, rdy);
    obs_v = {busy, idle, err}; exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v) $display("FAIL err_sticky: busy/idle/err=%h required %h", obs_v, exp_v);
    else passed++;
    step(1, 1, 5'd8, 1, 5'd0, 3'b000, 1, 5'd2, 0, 5'd0, 1, rdy);
    obs_v = {busy, idle, err}; exp_v = sb.pop_front(); total++;
    if (obs_v !== exp_v) $display("FAIL reset_midop: busy/idle/err=%h required %h", obs_v, exp_v);
    else passed++;
    step(0, 1, 5'd0, 0, 5'd6, 3'b111, 0, 5'd0, 0, 5'd0, 1, rdy);
    total++;
    if (rdy !== 1'b1) $display("FAIL reset_midop_ready: issue_ready=%b required 1", rdy); else passed++;
    void'(sb.pop_front());
  endtask

  initial begin
    test_reset();
    test_raw();
    test_saturation();
    test_simultaneous();
    test_kill_wb();
    test_underflow_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
